pipelined_adder: RTL and testbench



---
 rtl/pipelined_adder.sv | 182 ++++++++++++++++++
 tb/tb_pipelined_adder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: INPUT_SIZE-bit add/subtract split into STAGES carry-ripple
// segments with the inter-segment carry registered. Valid/ready handshake with
// a single global stall; carry-out and signed-overflow flags on the output.
// Optional probe outputs (A^Beff, A&Beff, per-bit carry) are compiled in when
// the macro PIPELINED_ADDER_PROBE_EN is defined.
module pipelined_adder #(
    parameter int INPUT_SIZE = 8,
    parameter int STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INPUT_SIZE-1:0] a,
    input  logic [INPUT_SIZE-1:0] b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INPUT_SIZE-1:0] sum,
    output logic                  cout,
    output logic                  ovf
`ifdef PIPELINED_ADDER_PROBE_EN
    ,
    output logic [INPUT_SIZE-1:0] axorb_out,
    output logic [INPUT_SIZE-1:0] aandb_out,
    output logic [INPUT_SIZE-1:0] carry_out
`endif
);

    localparam int SEG = INPUT_SIZE / STAGES;

    logic                  w_stall;
    logic [INPUT_SIZE-1:0] w_b_eff;
    logic                  w_c0;

    // Operand conditioning happens once, at acceptance: subtract is A + ~B + 1.
    assign w_b_eff = sub ? ~b : b;
    assign w_c0    = sub ? 1'b1 : cin;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            // REM: operand bits still unprocessed when entering this stage.
            // DONE: result bits known once this stage has registered.
            localparam int REM  = INPUT_SIZE - k * SEG;
            localparam int DONE = (k + 1) * SEG;

            logic [REM-1:0]  w_a_in;
            logic [REM-1:0]  w_b_in;
            logic            w_c_in;
            logic            w_v_in;
            logic [SEG:0]    w_seg;
            logic [DONE-1:0] w_sum_nxt;

            logic            r_v;
            logic            r_c;
            logic [DONE-1:0] r_sum;

`ifdef PIPELINED_ADDER_PROBE_EN
            logic [SEG-1:0]  w_px;
            logic [SEG-1:0]  w_pn;
            logic [SEG-1:0]  w_pc;
            logic [DONE-1:0] w_x_nxt;
            logic [DONE-1:0] w_n_nxt;
            logic [DONE-1:0] w_co_nxt;
            logic [DONE-1:0] r_x;
            logic [DONE-1:0] r_n;
            logic [DONE-1:0] r_co;
`endif

            if (k == 0) begin : g_src
                assign w_a_in    = a;
                assign w_b_in    = w_b_eff;
                assign w_c_in    = w_c0;
                assign w_v_in    = in_valid;
                assign w_sum_nxt = w_seg[SEG-1:0];
`ifdef PIPELINED_ADDER_PROBE_EN
                assign w_x_nxt   = w_px;
                assign w_n_nxt   = w_pn;
                assign w_co_nxt  = w_pc;
`endif
            end else begin : g_src
                assign w_a_in    = g_stage[k-1].g_fwd.r_a;
                assign w_b_in    = g_stage[k-1].g_fwd.r_b;
                assign w_c_in    = g_stage[k-1].r_c;
                assign w_v_in    = g_stage[k-1].r_v;
                // Lower partial sums move forward unchanged under the new segment.
                assign w_sum_nxt = {w_seg[SEG-1:0], g_stage[k-1].r_sum};
`ifdef PIPELINED_ADDER_PROBE_EN
                assign w_x_nxt   = {w_px, g_stage[k-1].r_x};
                assign w_n_nxt   = {w_pn, g_stage[k-1].r_n};
                assign w_co_nxt  = {w_pc, g_stage[k-1].r_co};
`endif
            end

            // Segment ripple add, SEG+1 bits wide so the top bit is the carry out.
            assign w_seg = {1'b0, w_a_in[SEG-1:0]} + {1'b0, w_b_in[SEG-1:0]}
                         + {{SEG{1'b0}}, w_c_in};

`ifdef PIPELINED_ADDER_PROBE_EN
            // Per-bit propagate/generate; carry into bit i is a^b^sum at bit i.
            assign w_px = w_a_in[SEG-1:0] ^ w_b_in[SEG-1:0];
            assign w_pn = w_a_in[SEG-1:0] & w_b_in[SEG-1:0];
            assign w_pc = w_pn | (w_px & (w_px ^ w_seg[SEG-1:0]));

            // Probe registers travel with the sum and hold under stall.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_x  <= '0;
                    r_n  <= '0;
                    r_co <= '0;
                end else if (!w_stall) begin
                    r_x  <= w_x_nxt;
                    r_n  <= w_n_nxt;
                    r_co <= w_co_nxt;
                end
            end
`endif

            // Stage state: valid bit, carry into the next segment, accumulated sum.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v   <= 1'b0;
                    r_c   <= 1'b0;
                    r_sum <= '0;
                end else if (!w_stall) begin
                    r_v   <= w_v_in;
                    r_c   <= w_seg[SEG];
                    r_sum <= w_sum_nxt;
                end
            end

            if (k < STAGES - 1) begin : g_fwd
                logic [REM-SEG-1:0] r_a;
                logic [REM-SEG-1:0] r_b;

                // Carry the operand bits that later stages still have to add.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else if (!w_stall) begin
                        r_a <= w_a_in[REM-1:SEG];
                        r_b <= w_b_in[REM-1:SEG];
                    end
                end
            end else begin : g_last
                logic w_c_msb;
                logic r_ovf;

                // Carry into the MSB recovered from the MSB's own sum bit.
                assign w_c_msb = w_a_in[SEG-1] ^ w_b_in[SEG-1] ^ w_seg[SEG-1];

                // Signed overflow: carry into MSB differs from carry out of MSB.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_ovf <= 1'b0;
                    end else if (!w_stall) begin
                        r_ovf <= w_c_msb ^ w_seg[SEG];
                    end
                end
            end
        end
    endgenerate

    // A held output beat freezes the whole pipeline, bubbles included.
    assign w_stall   = g_stage[STAGES-1].r_v & ~out_ready;
    assign in_ready  = ~w_stall;

    assign out_valid = g_stage[STAGES-1].r_v;
    assign sum       = g_stage[STAGES-1].r_sum;
    assign cout      = g_stage[STAGES-1].r_c;
    assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

`ifdef PIPELINED_ADDER_PROBE_EN
    assign axorb_out = g_stage[STAGES-1].r_x;
    assign aandb_out = g_stage[STAGES-1].r_n;
    assign carry_out = g_stage[STAGES-1].r_co;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Testbench for pipelined_adder (INPUT_SIZE=8, STAGES=2): directed vector table,
// streaming / stall / mid-flight reset sequences, and a randomized run against
// an arithmetic reference model with a scoreboard queue.
module tb_pipelined_adder;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
`ifdef PIPELINED_ADDER_PROBE_EN
    logic [W-1:0] axorb_out;
    logic [W-1:0] aandb_out;
    logic [W-1:0] carry_out;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    pipelined_adder #(.INPUT_SIZE(W), .STAGES(S)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
`ifdef PIPELINED_ADDER_PROBE_EN
        ,
        .axorb_out (axorb_out),
        .aandb_out (aandb_out),
        .carry_out (carry_out)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        logic [W-1:0] x;
        logic [W-1:0] n;
        logic [W-1:0] c;
    } res_t;

    // Reference: plain integer arithmetic on the specified effective operands.
    function automatic res_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                   input logic fc, input logic fs);
        res_t         r;
        logic [W-1:0] be;
        longint       ua, ub, c0, full, sa, sb, sres, mask, t;
        be   = fs ? ~fb : fb;
        c0   = fs ? 64'sd1 : longint'(fc);
        ua   = longint'(fa);
        ub   = longint'(be);
        full = ua + ub + c0;
        r.s  = full[W-1:0];
        r.co = full[W];
        sa   = fa[W-1] ? ua - (64'sd1 <<< W) : ua;
        sb   = be[W-1] ? ub - (64'sd1 <<< W) : ub;
        sres = sa + sb + c0;
        r.ov = (sres > (64'sd1 <<< (W-1)) - 64'sd1) || (sres < -(64'sd1 <<< (W-1)));
        r.x  = fa ^ be;
        r.n  = fa & be;
        for (int i = 0; i < W; i++) begin
            mask   = (64'sd1 <<< (i + 1)) - 64'sd1;
            t      = (ua & mask) + (ub & mask) + c0;
            r.c[i] = t[i+1];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard / protocol monitor, sampling on the falling edge.
    res_t         exp_q[$];
    res_t         e;
    logic [W-1:0] got_q[$];
    int           got_c[$];
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_sum;
    logic         prev_cout, prev_ovf;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (prev_stall) begin
                chk("stall_hold_valid", 64'(out_valid), 64'd1);
                chk("stall_hold_sum", 64'(sum), 64'(prev_sum));
                chk("stall_hold_flags", 64'({cout, ovf}), 64'({prev_cout, prev_ovf}));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_beat: got sum %0h with no beat outstanding", sum);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_sum", 64'(sum), 64'(e.s));
                    chk("sb_cout", 64'(cout), 64'(e.co));
                    chk("sb_ovf", 64'(ovf), 64'(e.ov));
`ifdef PIPELINED_ADDER_PROBE_EN
                    chk("sb_axorb", 64'(axorb_out), 64'(e.x));
                    chk("sb_aandb", 64'(aandb_out), 64'(e.n));
                    chk("sb_carry", 64'(carry_out), 64'(e.c));
`endif
                    got_q.push_back(sum);
                    got_c.push_back(cyc);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            prev_cout  = cout;
            prev_ovf   = ovf;
        end
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t          tv[7];
    logic [W-1:0]  exp_stream[4];
    int            lat;
    int            idx;
    int            cnt;
    logic          acc;

    initial begin
        tv[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        tv[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        tv[3] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
        tv[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        tv[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        tv[6] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
        exp_stream = '{8'h11, 8'h22, 8'h33, 8'h44};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_flags", 64'({cout, ovf}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed single beats: value and latency.
        for (int i = 0; i < 7; i++) begin
            a = tv[i].a; b = tv[i].b; cin = tv[i].cin; sub = tv[i].sub;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                tick();
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(S));
            chk($sformatf("vec%0d_sum", i), 64'(sum), 64'(tv[i].s));
            chk($sformatf("vec%0d_cout", i), 64'(cout), 64'(tv[i].co));
            chk($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(tv[i].ov));
            tick();
        end

        // Back-to-back stream, no backpressure: consecutive results.
        got_q.delete(); got_c.delete();
        sub = 1'b0; cin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = W'((i + 1) * 16); b = W'(i + 1); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (S + 2) tick();
        chk("stream_count", 64'(got_q.size()), 64'd4);
        if (got_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("stream_sum%0d", i), 64'(got_q[i]), 64'(exp_stream[i]));
                chk($sformatf("stream_gap%0d", i), 64'(got_c[i] - got_c[0]), 64'(i));
            end
        end

        // Same stream with 3 cycles of backpressure mid-stream; sender holds.
        got_q.delete(); got_c.delete();
        idx = 0;
        for (int cy = 0; cy < 30 && got_q.size() < 4; cy++) begin
            out_ready = !(cy >= 2 && cy < 5);
            if (idx < 4) begin
                a = W'((idx + 1) * 16); b = W'(idx + 1); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cy == 3) chk("stall_in_ready", 64'(in_ready), 64'd0);
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        chk("stall_count", 64'(got_q.size()), 64'd4);
        if (got_q.size() == 4) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("stall_sum%0d", i), 64'(got_q[i]), 64'(exp_stream[i]));
        end

        // Reset with two beats in flight: both dropped.
        a = 8'h11; b = 8'h22; in_valid = 1'b1;
        tick();
        a = 8'h33; b = 8'h44;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_sum", 64'(sum), 64'd0);
        chk("midrst_flags", 64'({cout, ovf}), 64'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) cnt++;
            tick();
        end
        chk("midrst_no_stale", 64'(cnt), 64'd0);

        // Randomized traffic with random backpressure.
        got_q.delete(); got_c.delete();
        acc = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        chk("random_drained", 64'(exp_q.size()), 64'd0);
        chk("random_activity", 64'(got_q.size() > 500), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
